data_mem_arbiter: RTL and testbench

- Shares the single data RAM (Ram_32_65536: registered output, 1-cycle read latency) between two requesters:
  - the processor load/store port (CPU);
  - a DMA/debug loader port (DMA) that preloads and inspects data memory.
- Sits between the processor datapath and the RAM.
- Generates Cpu_Stall so the processor freezes its PC and register writeback until its access completes.
- Fixed CPU priority, with a bounded-burst rule that guarantees DMA forward progress.

---
 rtl/data_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Shares one pipelined data RAM (registered output, 1-cycle read latency) between the
// processor load/store port (CPU) and a DMA/debug loader port (DMA).
//
// Arbitration: the CPU has fixed priority. While the DMA is waiting, at most MAX_BURST
// consecutive CPU grants are given before the DMA is served, so the DMA always makes
// forward progress. One access per grant cycle; grants may be back-to-back every cycle.
//
// Build option:
//   ARB_STATS_EN  defined   -> Conflict_Cnt counts cycles with both ports requesting
//                             (16-bit, saturating).
//                 undefined -> Conflict_Cnt is tied to 0.
//
// Ports:
//   Clk, Rst_n                      clock (rising edge), async active-low reset
//   Cpu_Req/Wr/Addr/Wdata           CPU access request (Req held until done)
//   Cpu_Gnt, Cpu_Rvalid, Cpu_Rdata  CPU grant, read-data valid pulse, read data
//   Cpu_Stall                       processor must hold PC and writeback this cycle
//   Dma_Req/Wr/Addr/Wdata           DMA access request
//   Dma_Gnt, Dma_Rvalid, Dma_Rdata  DMA grant, read-data valid pulse, read data
//   Ram_Addr/Data/Rden/Wren         to the RAM
//   Ram_Q                           from the RAM (valid the cycle after a read strobe)
//   Conflict_Cnt                    contention statistics

module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,

  input  logic              Cpu_Req,
  input  logic              Cpu_Wr,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic [DATA_W-1:0] Cpu_Wdata,
  output logic              Cpu_Gnt,
  output logic              Cpu_Rvalid,
  output logic [DATA_W-1:0] Cpu_Rdata,
  output logic              Cpu_Stall,

  input  logic              Dma_Req,
  input  logic              Dma_Wr,
  input  logic [ADDR_W-1:0] Dma_Addr,
  input  logic [DATA_W-1:0] Dma_Wdata,
  output logic              Dma_Gnt,
  output logic              Dma_Rvalid,
  output logic [DATA_W-1:0] Dma_Rdata,

  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_Data,
  output logic              Ram_Rden,
  output logic              Ram_Wren,
  input  logic [DATA_W-1:0] Ram_Q,

  output logic [15:0]       Conflict_Cnt
);

  // MAX_BURST is at most 15, so a 4-bit counter always suffices.
  localparam int unsigned     CntW     = 4;
  localparam logic [CntW-1:0] MaxBurst = CntW'(MAX_BURST);

  // Registered state
  logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;   // 1: pending read belongs to DMA
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_gnt, dma_gnt;
  logic rd_gnt;
  logic cpu_rvalid, dma_rvalid;

  // ---------------------------------------------------------------------------------
  // Grant decision. Combinational so an access can be issued in the same cycle the
  // request appears; gated by Rst_n so nothing reaches the RAM while in reset.
  // ---------------------------------------------------------------------------------
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (Rst_n) begin
      if (Cpu_Req && (!Dma_Req || (burst_cnt_q < MaxBurst))) begin
        cpu_gnt = 1'b1;
      end else if (Dma_Req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Counts CPU grants taken while the DMA waits; any DMA grant or an idle DMA
  // restarts the window.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!Dma_Req || dma_gnt) begin
      burst_cnt_d = '0;
    end else if (cpu_gnt && (burst_cnt_q < MaxBurst)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------------
  // RAM mux: one access per grant cycle, idle bus drives zeros.
  // ---------------------------------------------------------------------------------
  always_comb begin
    Ram_Addr = '0;
    Ram_Data = '0;
    Ram_Rden = 1'b0;
    Ram_Wren = 1'b0;
    if (cpu_gnt) begin
      Ram_Addr = Cpu_Addr;
      Ram_Data = Cpu_Wdata;
      Ram_Wren = Cpu_Wr;
      Ram_Rden = ~Cpu_Wr;
    end else if (dma_gnt) begin
      Ram_Addr = Dma_Addr;
      Ram_Data = Dma_Wdata;
      Ram_Wren = Dma_Wr;
      Ram_Rden = ~Dma_Wr;
    end
  end

  // ---------------------------------------------------------------------------------
  // Read return tracking. The RAM output is registered, so the data for a read granted
  // in cycle N sits on Ram_Q during cycle N+1; rd_pend/rd_owner steer it to the
  // requester that issued it. A new read in cycle N+1 simply overwrites the tag.
  // ---------------------------------------------------------------------------------
  assign rd_gnt = (cpu_gnt & ~Cpu_Wr) | (dma_gnt & ~Dma_Wr);

  always_comb begin
    rd_pend_d  = rd_gnt;
    rd_owner_d = rd_gnt ? dma_gnt : rd_owner_q;
  end

  assign cpu_rvalid = rd_pend_q & ~rd_owner_q;
  assign dma_rvalid = rd_pend_q &  rd_owner_q;

  // Read data passes straight through in the valid cycle and is held afterwards.
  always_comb begin
    cpu_rdata_d = cpu_rvalid ? Ram_Q : cpu_rdata_q;
    dma_rdata_d = dma_rvalid ? Ram_Q : dma_rdata_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------------
  // Port outputs
  // ---------------------------------------------------------------------------------
  assign Cpu_Gnt    = cpu_gnt;
  assign Dma_Gnt    = dma_gnt;
  assign Cpu_Rvalid = cpu_rvalid;
  assign Dma_Rvalid = dma_rvalid;
  assign Cpu_Rdata  = cpu_rdata_d;
  assign Dma_Rdata  = dma_rdata_d;

  // A CPU write finishes in its grant cycle; a CPU read finishes only when its data
  // returns, so every read stalls at least its grant cycle.
  assign Cpu_Stall = Cpu_Req & ~((cpu_gnt & Cpu_Wr) | cpu_rvalid);

  // ---------------------------------------------------------------------------------
  // Contention statistics
  // ---------------------------------------------------------------------------------
`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (Cpu_Req && Dma_Req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign Conflict_Cnt = conflict_cnt_q;
`else
  assign Conflict_Cnt = '0;
`endif

  // ---------------------------------------------------------------------------------
  // Design assertions
  // ---------------------------------------------------------------------------------
  burst_range_a: assert property (@(posedge Clk) (MAX_BURST >= 1) && (MAX_BURST <= 15));

  gnt_onehot_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(cpu_gnt && dma_gnt));

  burst_bound_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    burst_cnt_q <= MaxBurst);

  strobe_excl_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(Ram_Rden && Ram_Wren));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a RAM model with 1-cycle registered read,
// a behavioural reference model checked against the DUT on every falling edge, and
// directed scenarios with hand-computed literal expectations.

module tb_data_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Cpu_Req, Cpu_Wr;
  logic [AW-1:0] Cpu_Addr;
  logic [DW-1:0] Cpu_Wdata;
  logic          Cpu_Gnt, Cpu_Rvalid, Cpu_Stall;
  logic [DW-1:0] Cpu_Rdata;
  logic          Dma_Req, Dma_Wr;
  logic [AW-1:0] Dma_Addr;
  logic [DW-1:0] Dma_Wdata;
  logic          Dma_Gnt, Dma_Rvalid;
  logic [DW-1:0] Dma_Rdata;
  logic [AW-1:0] Ram_Addr;
  logic [DW-1:0] Ram_Data;
  logic          Ram_Rden, Ram_Wren;
  logic [DW-1:0] Ram_Q;
  logic [15:0]   Conflict_Cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  data_mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_BURST(MB)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Cpu_Req     (Cpu_Req),
    .Cpu_Wr      (Cpu_Wr),
    .Cpu_Addr    (Cpu_Addr),
    .Cpu_Wdata   (Cpu_Wdata),
    .Cpu_Gnt     (Cpu_Gnt),
    .Cpu_Rvalid  (Cpu_Rvalid),
    .Cpu_Rdata   (Cpu_Rdata),
    .Cpu_Stall   (Cpu_Stall),
    .Dma_Req     (Dma_Req),
    .Dma_Wr      (Dma_Wr),
    .Dma_Addr    (Dma_Addr),
    .Dma_Wdata   (Dma_Wdata),
    .Dma_Gnt     (Dma_Gnt),
    .Dma_Rvalid  (Dma_Rvalid),
    .Dma_Rdata   (Dma_Rdata),
    .Ram_Addr    (Ram_Addr),
    .Ram_Data    (Ram_Data),
    .Ram_Rden    (Ram_Rden),
    .Ram_Wren    (Ram_Wren),
    .Ram_Q       (Ram_Q),
    .Conflict_Cnt(Conflict_Cnt)
  );

  // RAM: registered output, 1-cycle read latency, no reset.
  logic [DW-1:0] ram_mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram_mem[i] = '0;
    Ram_Q = '0;
  end
  always @(posedge Clk) begin
    if (Ram_Wren) ram_mem[Ram_Addr] <= Ram_Data;
    if (Ram_Rden) Ram_Q <= ram_mem[Ram_Addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // ---------------------------------------------------------------------------------
  // Reference model: the CPU wins unless the DMA has already waited through MB CPU
  // grants; reads return one cycle after the grant with the memory image as of the
  // grant; each port's read data holds after its valid pulse.
  // ---------------------------------------------------------------------------------
  bit [31:0] ref_mem [int];
  int        m_streak = 0;
  bit        m_pend = 0, m_pend_dma = 0;
  bit [31:0] m_pend_data = 0, m_last_cpu = 0, m_last_dma = 0;
  int        m_conf = 0;

  int        n_streak;
  bit        n_pend, n_pend_dma, n_wr;
  bit [31:0] n_pend_data, n_last_cpu, n_last_dma, n_wr_data;
  int        n_wr_addr, n_conf;

  always @(negedge Clk) begin
    bit        e_cg, e_dg, e_crv, e_drv, e_rd, e_wr, e_stall;
    bit [31:0] e_addr, e_data, e_crd, e_drd;
    int        e_conf;
    if (!Rst_n) begin
      m_streak = 0; m_pend = 0; m_pend_dma = 0; m_pend_data = 0;
      m_last_cpu = 0; m_last_dma = 0; m_conf = 0;
    end
    e_cg = Rst_n && Cpu_Req && (!Dma_Req || m_streak < MB);
    e_dg = Rst_n && Dma_Req && !e_cg;
    e_crv = m_pend && !m_pend_dma;
    e_drv = m_pend && m_pend_dma;
    e_crd = e_crv ? m_pend_data : m_last_cpu;
    e_drd = e_drv ? m_pend_data : m_last_dma;
    e_addr = e_cg ? 32'(Cpu_Addr)  : e_dg ? 32'(Dma_Addr)  : 32'd0;
    e_data = e_cg ? Cpu_Wdata      : e_dg ? Dma_Wdata      : 32'd0;
    e_wr = (e_cg && Cpu_Wr) || (e_dg && Dma_Wr);
    e_rd = (e_cg && !Cpu_Wr) || (e_dg && !Dma_Wr);
    e_stall = Cpu_Req && !((e_cg && Cpu_Wr) || e_crv);
`ifdef ARB_STATS_EN
    e_conf = m_conf;
`else
    e_conf = 0;
`endif
    check("cpu_gnt",    32'(Cpu_Gnt),      32'(e_cg));
    check("dma_gnt",    32'(Dma_Gnt),      32'(e_dg));
    check("ram_rden",   32'(Ram_Rden),     32'(e_rd));
    check("ram_wren",   32'(Ram_Wren),     32'(e_wr));
    check("ram_addr",   32'(Ram_Addr),     e_addr);
    check("ram_data",   Ram_Data,          e_data);
    check("cpu_rvalid", 32'(Cpu_Rvalid),   32'(e_crv));
    check("dma_rvalid", 32'(Dma_Rvalid),   32'(e_drv));
    check("cpu_rdata",  Cpu_Rdata,         e_crd);
    check("dma_rdata",  Dma_Rdata,         e_drd);
    check("cpu_stall",  32'(Cpu_Stall),    32'(e_stall));
    check("conflict",   32'(Conflict_Cnt), 32'(e_conf));

    n_streak    = (Dma_Req && e_cg) ? m_streak + 1 : 0;
    n_pend      = e_rd;
    n_pend_dma  = e_dg;
    n_pend_data = ref_mem.exists(int'(e_addr)) ? ref_mem[int'(e_addr)] : 32'd0;
    n_wr        = e_wr;
    n_wr_addr   = int'(e_addr);
    n_wr_data   = e_data;
    n_last_cpu  = e_crd;
    n_last_dma  = e_drd;
    n_conf      = (Cpu_Req && Dma_Req && m_conf < 65535) ? m_conf + 1 : m_conf;
  end

  always @(posedge Clk) begin
    if (!Rst_n) begin
      m_streak = 0; m_pend = 0; m_pend_dma = 0; m_pend_data = 0;
      m_last_cpu = 0; m_last_dma = 0; m_conf = 0;
    end else begin
      m_streak    = n_streak;
      m_pend      = n_pend;
      m_pend_dma  = n_pend_dma;
      m_pend_data = n_pend_data;
      m_last_cpu  = n_last_cpu;
      m_last_dma  = n_last_dma;
      m_conf      = n_conf;
      if (n_wr) ref_mem[n_wr_addr] = n_wr_data;
    end
  end

  // ---------------------------------------------------------------------------------
  // Directed stimulus; inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [11:0] got_cpu;
  int          n_dma_gnt;

  initial begin
    Rst_n = 1'b0;
    Cpu_Req = 1'b1; Cpu_Wr = 1'b0; Cpu_Addr = '0; Cpu_Wdata = '0;
    Dma_Req = 1'b1; Dma_Wr = 1'b0; Dma_Addr = '0; Dma_Wdata = '0;

    // Reset: grants and strobes forced low even with both ports requesting
    @(negedge Clk);
    check("rst_cpu_gnt",  32'(Cpu_Gnt),      32'd0);
    check("rst_dma_gnt",  32'(Dma_Gnt),      32'd0);
    check("rst_rden",     32'(Ram_Rden),     32'd0);
    check("rst_wren",     32'(Ram_Wren),     32'd0);
    check("rst_conflict", 32'(Conflict_Cnt), 32'd0);
    check("rst_stall",    32'(Cpu_Stall),    32'd1);
    tick();
    tick();
    Rst_n = 1'b1; Cpu_Req = 1'b0; Dma_Req = 1'b0;

    // CPU write then read of 0x0010
    tick();
    Cpu_Req = 1'b1; Cpu_Wr = 1'b1; Cpu_Addr = 16'h0010; Cpu_Wdata = 32'hDEADBEEF;
    @(negedge Clk);
    check("t1_wr_gnt",   32'(Cpu_Gnt),   32'd1);
    check("t1_wr_stall", 32'(Cpu_Stall), 32'd0);
    tick();
    Cpu_Wr = 1'b0;
    @(negedge Clk);
    check("t1_rd_gnt",   32'(Cpu_Gnt),   32'd1);
    check("t1_rd_stall", 32'(Cpu_Stall), 32'd1);
    tick();
    Cpu_Req = 1'b0;
    @(negedge Clk);
    check("t1_rvalid", 32'(Cpu_Rvalid), 32'd1);
    check("t1_rdata",  Cpu_Rdata,       32'hDEADBEEF);

    // Both ports requesting for 12 cycles
    tick();
    Cpu_Req = 1'b1; Cpu_Wr = 1'b1; Cpu_Addr = 16'h0020; Cpu_Wdata = 32'h1234_0000;
    Dma_Req = 1'b1; Dma_Wr = 1'b1; Dma_Addr = 16'h0030; Dma_Wdata = 32'h5678_0000;
    n_dma_gnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      got_cpu[i] = Cpu_Gnt;
      if (Dma_Gnt) n_dma_gnt++;
      tick();
    end
    Cpu_Req = 1'b0; Dma_Req = 1'b0;
    check("t2_pattern",  32'(got_cpu),   32'h0000_0DEF);
    check("t2_dma_gnts", 32'(n_dma_gnt), 32'd2);
    @(negedge Clk);
`ifdef ARB_STATS_EN
    check("t2_conflict", 32'(Conflict_Cnt), 32'd12);
`else
    check("t2_conflict", 32'(Conflict_Cnt), 32'd0);
`endif

    // DMA read in N, CPU read in N+1, no cross-delivery
    tick();
    Dma_Req = 1'b1; Dma_Wr = 1'b1; Dma_Addr = 16'h0001; Dma_Wdata = 32'h1111_1111;
    tick();
    Dma_Req = 1'b0;
    Cpu_Req = 1'b1; Cpu_Wr = 1'b1; Cpu_Addr = 16'h0002; Cpu_Wdata = 32'h2222_2222;
    tick();
    Cpu_Req = 1'b0;
    Dma_Req = 1'b1; Dma_Wr = 1'b0; Dma_Addr = 16'h0001;
    @(negedge Clk);
    check("t3_dma_gnt", 32'(Dma_Gnt), 32'd1);
    tick();
    Dma_Req = 1'b0;
    Cpu_Req = 1'b1; Cpu_Wr = 1'b0; Cpu_Addr = 16'h0002;
    @(negedge Clk);
    check("t3_dma_rvalid", 32'(Dma_Rvalid), 32'd1);
    check("t3_dma_rdata",  Dma_Rdata,       32'h1111_1111);
    check("t3_cpu_rv_n1",  32'(Cpu_Rvalid), 32'd0);
    check("t3_cpu_gnt",    32'(Cpu_Gnt),    32'd1);
    tick();
    Cpu_Req = 1'b0;
    @(negedge Clk);
    check("t3_cpu_rvalid", 32'(Cpu_Rvalid), 32'd1);
    check("t3_cpu_rdata",  Cpu_Rdata,       32'h2222_2222);
    check("t3_dma_rv_n2",  32'(Dma_Rvalid), 32'd0);
    check("t3_dma_hold",   Dma_Rdata,       32'h1111_1111);

    // Idle for 5 cycles
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("t4_idle_rden",  32'(Ram_Rden),   32'd0);
      check("t4_idle_wren",  32'(Ram_Wren),   32'd0);
      check("t4_idle_stall", 32'(Cpu_Stall),  32'd0);
      check("t4_idle_crv",   32'(Cpu_Rvalid), 32'd0);
      check("t4_idle_drv",   32'(Dma_Rvalid), 32'd0);
      tick();
    end

    // Reset in the middle of a CPU read grant cycle
    Cpu_Req = 1'b1; Cpu_Wr = 1'b0; Cpu_Addr = 16'h0010;
    @(negedge Clk);
    check("t5_rd_gnt", 32'(Cpu_Gnt), 32'd1);
    #2;
    Rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("t5_rst_rvalid", 32'(Cpu_Rvalid), 32'd0);
      check("t5_rst_gnt",    32'(Cpu_Gnt),    32'd0);
    end
    tick();
    Rst_n = 1'b1;
    Dma_Req = 1'b1; Dma_Wr = 1'b0; Dma_Addr = 16'h0001;
    @(negedge Clk);
    check("t5_first_cpu_gnt", 32'(Cpu_Gnt),    32'd1);
    check("t5_first_dma_gnt", 32'(Dma_Gnt),    32'd0);
    check("t5_no_stale_rv",   32'(Cpu_Rvalid), 32'd0);
    tick();
    Cpu_Req = 1'b0; Dma_Req = 1'b0;
    @(negedge Clk);
    check("t5_new_rvalid", 32'(Cpu_Rvalid), 32'd1);
    check("t5_new_rdata",  Cpu_Rdata,       32'hDEADBEEF);

    // DMA-only stream: 3 writes then 3 back-to-back reads
    for (int i = 0; i < 3; i++) begin
      tick();
      Dma_Req = 1'b1; Dma_Wr = 1'b1;
      Dma_Addr = 16'h0100 + 16'(i); Dma_Wdata = 32'hA0A0_0000 + 32'(i);
      @(negedge Clk);
      check("t6_wr_gnt", 32'(Dma_Gnt), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      Dma_Wr = 1'b0; Dma_Addr = 16'h0100 + 16'(i);
      @(negedge Clk);
      check("t6_rd_gnt", 32'(Dma_Gnt), 32'd1);
      if (i > 0) begin
        check("t6_rvalid", 32'(Dma_Rvalid), 32'd1);
        check("t6_rdata",  Dma_Rdata,       32'hA0A0_0000 + 32'(i - 1));
      end
    end
    tick();
    Dma_Req = 1'b0;
    @(negedge Clk);
    check("t6_last_rvalid", 32'(Dma_Rvalid), 32'd1);
    check("t6_last_rdata",  Dma_Rdata,       32'hA0A0_0002);

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
